// File: rtl/opendap_pkg.sv
// Shared DAP definitions: AP register byte offsets, CSW field positions and
// downstream bus transfer-size encodings.
package opendap_pkg;

    localparam logic [7:0] AP_CSW  = 8'h00;
    localparam logic [7:0] AP_TAR  = 8'h04;
    localparam logic [7:0] AP_DRW  = 8'h0C;
    localparam logic [7:0] AP_BD0  = 8'h10;
    localparam logic [7:0] AP_BD1  = 8'h14;
    localparam logic [7:0] AP_BD2  = 8'h18;
    localparam logic [7:0] AP_BD3  = 8'h1C;
    localparam logic [7:0] AP_BASE = 8'hF8;
    localparam logic [7:0] AP_IDR  = 8'hFC;

    localparam int CSW_SIZE_LSB     = 0;
    localparam int CSW_SIZE_MSB     = 2;
    localparam int CSW_ADDRINC_LSB  = 4;
    localparam int CSW_ADDRINC_MSB  = 5;
    localparam int CSW_DEVEN_BIT    = 6;
    localparam int CSW_TRINPROG_BIT = 7;

    localparam logic [1:0] ADDRINC_OFF    = 2'b00;
    localparam logic [1:0] ADDRINC_SINGLE = 2'b01;

    typedef enum logic [1:0] {
        BUS_SIZE_BYTE = 2'd0,
        BUS_SIZE_HALF = 2'd1,
        BUS_SIZE_WORD = 2'd2
    } bus_size_e;

    // Sizes wider than a word are not supported; clamp to word.
    function automatic bus_size_e csw_size_legal(input logic [2:0] size);
        if (size > 3'd2) begin
            return BUS_SIZE_WORD;
        end
        return bus_size_e'(size[1:0]);
    endfunction

    // Packed increment modes are not supported; treat them as no increment.
    function automatic logic [1:0] csw_addrinc_legal(input logic [1:0] inc);
        return (inc == ADDRINC_SINGLE) ? ADDRINC_SINGLE : ADDRINC_OFF;
    endfunction

endpackage

// File: rtl/opendap_mem_ap.sv
// Memory access port: CSW/TAR/DRW register file fronting a single-request memory bus.
// Define OPENDAP_MEM_AP_BD_EN to enable the banked data registers BD0-BD3.
module opendap_mem_ap
    import opendap_pkg::*;
#(
    parameter logic [7:0]  APSEL = 8'd0,
    parameter logic [31:0] IDR   = 32'h0477_0001,
    parameter logic [31:0] BASE  = 32'h0000_0003
) (
    input  logic        swclk,
    input  logic        rst_n,

    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_wen,
    input  logic        ap_ren,
    input  logic        ap_abort,
    output logic [31:0] ap_rdata,
    output logic        ap_rdy,
    output logic        ap_err,

    output logic [31:0] bus_addr,
    output logic [1:0]  bus_size,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    // state  | meaning
    // S_IDLE | registers accessible, ap_rdy=1
    // S_BUS  | DRW/BD request outstanding on the bus, ap_rdy=0
    typedef enum logic {S_IDLE, S_BUS} state_e;

    state_e      state_q, state_d;
    bus_size_e   size_q, size_d;
    logic [1:0]  addrinc_q, addrinc_d;
    logic [31:0] tar_q, tar_d;
    logic [31:0] ap_rdata_q, ap_rdata_d;
    logic        ap_err_q, ap_err_d;
    logic        acc_bd_q, acc_bd_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    bus_size_e   bus_size_q, bus_size_d;
    logic        bus_write_q, bus_write_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_valid_q, bus_valid_d;

    logic        sel;
    logic [7:0]  byte_addr;
    logic        is_drw;
    logic        is_bd;
    logic [31:0] csw_rdata;
    logic [31:0] reg_rdata;
    logic [9:0]  tar_step;
    logic        bus_done;

    assign sel       = (ap_sel == APSEL);
    assign byte_addr = {ap_addr, 2'b00};
    assign is_drw    = (byte_addr == AP_DRW);

`ifdef OPENDAP_MEM_AP_BD_EN
    assign is_bd = (byte_addr == AP_BD0) || (byte_addr == AP_BD1) ||
                   (byte_addr == AP_BD2) || (byte_addr == AP_BD3);
`else
    assign is_bd = 1'b0;
`endif

    assign tar_step = 10'd1 << size_q;
    assign bus_done = (state_q == S_BUS) && !ap_abort && bus_ready;

    always_comb begin
        csw_rdata = '0;
        csw_rdata[CSW_SIZE_MSB:CSW_SIZE_LSB]       = {1'b0, size_q};
        csw_rdata[CSW_ADDRINC_MSB:CSW_ADDRINC_LSB] = addrinc_q;
        csw_rdata[CSW_DEVEN_BIT]                   = 1'b1;
        csw_rdata[CSW_TRINPROG_BIT]                = (state_q == S_BUS);
    end

    // Register read mux; unlisted offsets (including BD when disabled) are RAZ.
    always_comb begin
        reg_rdata = '0;
        case (byte_addr)
            AP_CSW:  reg_rdata = csw_rdata;
            AP_TAR:  reg_rdata = tar_q;
            AP_BASE: reg_rdata = BASE;
            AP_IDR:  reg_rdata = IDR;
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        addrinc_d   = addrinc_q;
        tar_d       = tar_q;
        ap_rdata_d  = ap_rdata_q;
        ap_err_d    = 1'b0;
        acc_bd_d    = acc_bd_q;
        bus_addr_d  = bus_addr_q;
        bus_size_d  = bus_size_q;
        bus_write_d = bus_write_q;
        bus_wdata_d = bus_wdata_q;
        bus_valid_d = bus_valid_q;

        case (state_q)
            S_IDLE: begin
                if (ap_wen || ap_ren) begin
                    if (!sel) begin
                        if (ap_ren) begin
                            ap_rdata_d = '0;
                        end
                    end else if (is_drw || is_bd) begin
                        state_d     = S_BUS;
                        bus_valid_d = 1'b1;
                        bus_write_d = ap_wen;
                        acc_bd_d    = is_bd;
                        if (ap_wen) begin
                            bus_wdata_d = ap_wdata;
                        end
                        if (is_bd) begin
                            bus_addr_d = {tar_q[31:4], ap_addr[1:0], 2'b00};
                            bus_size_d = BUS_SIZE_WORD;
                        end else begin
                            bus_addr_d = tar_q;
                            bus_size_d = size_q;
                        end
                    end else if (ap_wen) begin
                        case (byte_addr)
                            AP_CSW: begin
                                size_d    = csw_size_legal(ap_wdata[CSW_SIZE_MSB:CSW_SIZE_LSB]);
                                addrinc_d = csw_addrinc_legal(ap_wdata[CSW_ADDRINC_MSB:CSW_ADDRINC_LSB]);
                            end
                            AP_TAR:  tar_d = ap_wdata;
                            default: ;
                        endcase
                    end else begin
                        ap_rdata_d = reg_rdata;
                    end
                end
            end

            S_BUS: begin
                // Abort wins over a same-cycle completion.
                if (ap_abort) begin
                    state_d     = S_IDLE;
                    bus_valid_d = 1'b0;
                end else if (bus_done) begin
                    state_d     = S_IDLE;
                    bus_valid_d = 1'b0;
                    ap_err_d    = bus_err;
                    if (!bus_write_q) begin
                        ap_rdata_d = bus_rdata;
                    end
                    if (!bus_err && !acc_bd_q && (addrinc_q == ADDRINC_SINGLE)) begin
                        tar_d = {tar_q[31:10], tar_q[9:0] + tar_step};
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            size_q      <= BUS_SIZE_WORD;
            addrinc_q   <= ADDRINC_OFF;
            tar_q       <= '0;
            ap_rdata_q  <= '0;
            ap_err_q    <= 1'b0;
            acc_bd_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_size_q  <= BUS_SIZE_WORD;
            bus_write_q <= 1'b0;
            bus_wdata_q <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            addrinc_q   <= addrinc_d;
            tar_q       <= tar_d;
            ap_rdata_q  <= ap_rdata_d;
            ap_err_q    <= ap_err_d;
            acc_bd_q    <= acc_bd_d;
            bus_addr_q  <= bus_addr_d;
            bus_size_q  <= bus_size_d;
            bus_write_q <= bus_write_d;
            bus_wdata_q <= bus_wdata_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign ap_rdata  = ap_rdata_q;
    assign ap_rdy    = (state_q == S_IDLE);
    assign ap_err    = ap_err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_size  = bus_size_q;
    assign bus_write = bus_write_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_valid = bus_valid_q;

endmodule
